ioport_tx: RTL and testbench
============================

# ioport_tx

Byte-stream transmitter for the emulated I/O port. It accepts `WIDTH_BYTES`-wide words on a valid/ready input and emits them one byte per cycle, most-significant byte first, on a valid/ready byte output. The byte order is the order the port receiver packs: the first byte on the wire lands in the top byte of the receiver's word. A small word FIFO decouples the producer from output back-pressure.

## Interface
- `WIDTH_BYTES`, default 4: bytes per word; must be at least 1.
- `FIFO_DEPTH`, default 2: word FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_data`  in  WIDTH_BYTES*8  word to send; bits [WIDTH_BYTES*8-1 -: 8] go out first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a word; reset value 1.
- `out_byte`  out  8  current byte; reset value 0.
- `out_valid`  out  1  `out_byte` is valid; reset value 0.
- `out_last`  out  1  `out_byte` is the final (least-significant) byte of its word; reset value 0.
- `out_ready`  in  1  consumer accepts the byte.
- `busy`  out  1  FIFO not empty or serializer loaded; reset value 0.
- `words_sent`  out  16  count of words whose last byte has completed; wraps at 2^16; reset value 0.

## Operation
- An input handshake is `in_valid && in_ready` at a rising edge. It writes `in_data` to the FIFO tail.
- An output handshake is `out_valid && out_ready` at a rising edge.
- Serializer FSM:
  - IDLE: `out_valid`=0.
    - If the FIFO is non-empty, pop the head into the shift register, set `idx`=WIDTH_BYTES-1 and go to SEND.
  - SEND: `out_byte` = shift register byte `idx`; `out_last` = (`idx`==0).
    - On an output handshake with `idx`>0: decrement `idx`.
    - On an output handshake with `idx`==0: increment `words_sent`.
      - If the FIFO is non-empty, pop the next word and reload on the same edge. `idx`=WIDTH_BYTES-1, stay in SEND with no bubble.
      - Otherwise go to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_byte` and `out_last` hold steady.
- `in_ready` = !full, computed from the registered occupancy count only. A full FIFO deasserts `in_ready` even during a cycle in which the FIFO is popped. There is no combinational path from `out_ready` to `in_ready`.
- A push and a pop on the same edge leave the occupancy unchanged. Read and write pointers wrap modulo `FIFO_DEPTH`.
- When WIDTH_BYTES=1, every byte has `out_last`=1.
- Asserting reset mid-word discards the FIFO and the partial word. Outputs take their reset values immediately, without waiting for a clock edge. Nothing is retransmitted after reset.
- `in_data` is ignored when `in_valid`=0. `out_ready` is ignored when `out_valid`=0.

## Timing
- Latency: word accepted at edge N with the serializer in IDLE and the FIFO empty → `out_valid`=1 with the MSB byte after edge N+1.
- Throughput: 1 byte/cycle sustained under continuous `out_ready`=1. One word takes WIDTH_BYTES cycles; consecutive words have no gap.
- `words_sent` updates on the same edge as the handshake of the word's last byte.
- `busy` is registered and falls on the edge that completes the last byte when the FIFO is empty.
- Total buffering is FIFO_DEPTH words plus 1 word in the shift register.

## Structure
- Shared package `ioport_pkg`:
  - serializer state enum {IDLE, SEND};
  - index-width constant/function `$clog2` of WIDTH_BYTES, minimum 1;
  - byte width constant 8.
- Sub-module `ioport_tx_fifo`: parameterized synchronous word FIFO.
  - Ports: push, pop, full, empty, count.
  - First-word data presented at the head, with no read latency.
- The top level holds the FSM, shift register, `idx`, and `words_sent`.

## Test plan
- Reset then single word, WIDTH_BYTES=4: push 0xA1B2C3D4 with `out_ready`=1.
  - Required: bytes A1, B2, C3, D4 on four consecutive cycles, starting one edge after the push.
  - Required: `out_last` high only on D4; `words_sent`=1; `busy` falls after D4.
- Back-pressure: push 0x11223344 and hold `out_ready`=0 for 5 cycles, then release.
  - Required: `out_byte`=0x11 is stable throughout the stall.
  - Required: after release, 22, 33, 44 follow.
- Full FIFO: `out_ready`=0 with FIFO_DEPTH=2.
  - Push 3 words; `in_ready` falls after the third push: 1 word in the shift register, 2 in the FIFO.
  - A fourth `in_valid` is not accepted.
  - Release `out_ready`: all 12 bytes emerge in order, with no gaps between words.
- Simultaneous push/pop at full: stall at full, then in the pop cycle present a new word.
  - Required: `in_ready`=0 that cycle and the word is not taken.
  - Required: it is accepted the following cycle.
- Reset mid-word: assert `rst_n`=0 after 2 of 4 bytes.
  - Required: `out_valid`=0 and `busy`=0 asynchronously.
  - Required: after release, `words_sent`=0 and no residual bytes appear.
- Wrap: preload `words_sent` by sending 65536 one-byte words with WIDTH_BYTES=1.
  - Required: the count returns to 0.
  - Required: `out_last`=1 on every byte.

Source files
------------

// File: rtl/ioport_pkg.sv
// rtl/ioport_pkg.sv - shared types and constants for the I/O port transmitter
package ioport_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  // Byte-index width; a one-byte word still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ioport_tx_fifo.sv
// rtl/ioport_tx_fifo.sv - synchronous word FIFO with zero-latency head
module ioport_tx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ioport_tx.sv
// rtl/ioport_tx.sv - word-to-byte serializer, MSB first, with word FIFO
module ioport_tx
  import ioport_pkg::*;
#(
  parameter int WIDTH_BYTES = 4,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH_BYTES*BYTE_W-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [BYTE_W-1:0]             out_byte,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [15:0]                   words_sent
);

  localparam int WORD_W = WIDTH_BYTES * BYTE_W;
  localparam int IDX_W  = idx_width(WIDTH_BYTES);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH_BYTES - 1);

  logic              fifo_full, fifo_empty, push, pop, load;
  logic [WORD_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count, count_next;
  logic [IDX_W-1:0]  idx_dec;
  logic [BYTE_W-1:0] dec_byte;

  ser_state_e        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BYTE_W-1:0] out_byte_q, out_byte_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic [15:0]       words_sent_q, words_sent_d;

  // in_ready depends only on the registered occupancy, never on out_ready.
  assign in_ready = !fifo_full;
  assign push     = in_valid && !fifo_full;

  ioport_tx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    idx_dec  = idx_q - 1'b1;
    dec_byte = '0;
    for (int i = 0; i < WIDTH_BYTES; i++) begin
      if (IDX_W'(i) == idx_dec) begin
        dec_byte = shreg_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    out_byte_d   = out_byte_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    words_sent_d = words_sent_q;
    pop          = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        load = !fifo_empty;
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q != '0) begin
            idx_d      = idx_dec;
            out_byte_d = dec_byte;
            out_last_d = (idx_dec == '0);
          end else begin
            words_sent_d = words_sent_q + 16'd1;
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    // A load on the last-byte handshake gives back-to-back words with no bubble.
    if (load) begin
      pop         = 1'b1;
      shreg_d     = fifo_head;
      idx_d       = IDX_TOP;
      state_d     = SEND;
      out_valid_d = 1'b1;
      out_byte_d  = fifo_head[WORD_W-1 -: BYTE_W];
      out_last_d  = (WIDTH_BYTES == 1);
    end

    count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
    busy_d     = (state_d == SEND) || (count_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      out_byte_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      out_byte_q   <= out_byte_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign out_byte   = out_byte_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule

// File: tb/tb_ioport_tx.sv
// tb/tb_ioport_tx.sv - self-checking bench for ioport_tx (4-byte and 1-byte words)
module tb_ioport_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-byte instance
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, busy;
  logic [7:0]  out_byte;
  logic [15:0] words_sent;

  // 1-byte instance for the counter wrap
  logic        rst1_n = 1'b0;
  logic [7:0]  in_data_1 = '0;
  logic        in_valid_1 = 1'b0, out_ready_1 = 1'b1;
  logic        in_ready_1, out_valid_1, out_last_1, busy_1;
  logic [7:0]  out_byte_1;
  logic [15:0] words_sent_1;

  ioport_tx #(.WIDTH_BYTES(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .words_sent(words_sent)
  );

  ioport_tx #(.WIDTH_BYTES(1), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_data(in_data_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .out_byte(out_byte_1), .out_valid(out_valid_1), .out_last(out_last_1), .out_ready(out_ready_1),
    .busy(busy_1), .words_sent(words_sent_1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: every accepted word becomes WIDTH_BYTES queued bytes, MSB first,
  // each tagged with the edge at which its word was accepted.
  typedef struct {
    logic [7:0] b;
    logic       last;
    int         tag;
  } exp_byte_t;

  exp_byte_t   mq[$];
  int          edge_n = 0;
  logic [15:0] m_ws = '0;
  logic        ev;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      mq.delete();
      m_ws = '0;
    end else begin
      if (out_valid && out_ready && mq.size() > 0) begin
        if (mq[0].last) m_ws++;
        void'(mq.pop_front());
      end
      if (in_valid && in_ready) begin
        for (int k = 3; k >= 0; k--) mq.push_back('{in_data[k*8 +: 8], (k == 0), edge_n});
      end
    end
  end

  // A word accepted at edge N is first visible after edge N+1.
  always @(negedge clk) begin
    if (rst_n) begin
      ev = (mq.size() > 0) && (mq[0].tag < edge_n);
      check("m_valid", 32'(out_valid), 32'(ev));
      check("m_busy", 32'(busy), 32'(mq.size() > 0));
      check("m_words", 32'(words_sent), 32'(m_ws));
      if (ev) begin
        check("m_byte", 32'(out_byte), 32'(mq[0].b));
        check("m_last", 32'(out_last), 32'(mq[0].last));
      end
    end
  end

  // Wrap stimulus and checking on the 1-byte instance
  int pushed1 = 0;
  int got1 = 0;

  initial begin
    repeat (2) step();
    rst1_n = 1'b1;
    in_valid_1 = 1'b1;
    while (pushed1 < 65536) begin
      @(posedge clk);
      if (in_valid_1 && in_ready_1) pushed1++;
      #1 in_data_1 = pushed1[7:0];
    end
    in_valid_1 = 1'b0;
  end

  always @(posedge clk) if (rst1_n && out_valid_1 && out_ready_1) got1++;

  always @(negedge clk) begin
    if (rst1_n && out_valid_1) begin
      check("w1_last", 32'(out_last_1), 32'd1);
      check("w1_byte", 32'(out_byte_1), 32'(got1[7:0]));
      check("w1_words", 32'(words_sent_1), 32'(got1[15:0]));
      if (got1 == 65535) check("w1_pre_wrap", 32'(words_sent_1), 32'hFFFF);
    end
  end

  logic [31:0] w;

  initial begin
    repeat (2) step();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_sent), 32'd0);
    rst_n = 1'b1;
    step();

    // Single word, free-flowing output
    out_ready = 1'b1;
    w = 32'hA1B2C3D4;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_lat_gap", 32'(out_valid), 32'd0);
    step();
    for (int k = 3; k >= 0; k--) begin
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_byte", 32'(out_byte), 32'(w[k*8 +: 8]));
      check("t1_last", 32'(out_last), 32'(k == 0));
      check("t1_busy", 32'(busy), 32'd1);
      step();
    end
    check("t1_idle", 32'(out_valid), 32'd0);
    check("t1_busy_fall", 32'(busy), 32'd0);
    check("t1_words", 32'(words_sent), 32'd1);

    // Back-pressure stall
    out_ready = 1'b0;
    w = 32'h11223344;
    in_data = w; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    repeat (5) begin
      check("t2_stall_valid", 32'(out_valid), 32'd1);
      check("t2_stall_byte", 32'(out_byte), 32'h11);
      step();
    end
    out_ready = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      check("t2_byte", 32'(out_byte), 32'(w[k*8 +: 8]));
      step();
    end
    check("t2_words", 32'(words_sent), 32'd2);

    // Fill: one word in the shift register, two in the FIFO
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h01020304; step();
    check("t3_ready1", 32'(in_ready), 32'd1);
    in_data = 32'h05060708; step();
    check("t3_ready2", 32'(in_ready), 32'd1);
    in_data = 32'h090A0B0C; step();
    check("t3_full", 32'(in_ready), 32'd0);
    in_data = 32'hDEADBEEF; step();
    check("t3_reject", 32'(in_ready), 32'd0);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("t3_nogap", 32'(out_valid), 32'd1);
      check("t3_byte", 32'(out_byte), 32'(i + 1));
      step();
    end
    check("t3_drained", 32'(out_valid), 32'd0);
    check("t3_words", 32'(words_sent), 32'd5);

    // Push offered on the very edge that pops a full FIFO
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h10111213; step();
    in_data = 32'h20212223; step();
    in_data = 32'h30313233; step();
    in_valid = 1'b0;
    check("t4_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    repeat (3) step();
    check("t4_last_byte", 32'(out_byte), 32'h13);
    check("t4_last_flag", 32'(out_last), 32'd1);
    in_data = 32'h40414243; in_valid = 1'b1;
    check("t4_pop_cycle_ready", 32'(in_ready), 32'd0);
    step();
    check("t4_next_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && busy; c++) step();
    check("t4_busy_done", 32'(busy), 32'd0);
    check("t4_words", 32'(words_sent), 32'd9);

    // Reset in the middle of a word
    in_data = 32'hCAFEF00D; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("t5_mid_byte", 32'(out_byte), 32'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_last", 32'(out_last), 32'd0);
    check("t5_async_words", 32'(words_sent), 32'd0);
    check("t5_async_ready", 32'(in_ready), 32'd1);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) begin
      check("t5_no_residue", 32'(out_valid), 32'd0);
      step();
    end
    check("t5_words", 32'(words_sent), 32'd0);

    // Wait for the 1-byte counter wrap to finish
    for (int c = 0; c < 70000 && got1 < 65536; c++) step();
    check("w1_done", 32'(got1), 32'd65536);
    step();
    check("w1_wrap", 32'(words_sent_1), 32'd0);
    check("w1_busy", 32'(busy_1), 32'd0);
    check("w1_idle", 32'(out_valid_1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
